// File: rtl/proc_control.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module      : proc_control                                             |
// | Description : Multicycle control unit of the simple bus processor.     |
// |               Owns the instruction register and the T0..T3 step        |
// |               counter, and sequences register-file, A, G and DIN       |
// |               transfers over the shared bus.                           |
// |               Optional feature macro: CTRL_ILLEGAL_EN adds the sticky  |
// |               Illegal output for undefined opcodes.                    |
// | Revision    : 1.0 - initial release                                    |
// +------------------------------------------------------------------------+
module proc_control #(
  parameter int W = 16
) (
  input  logic         Clock,
  input  logic         Resetn,
  input  logic         Run,
  input  logic [W-1:0] DIN,
  output logic [7:0]   Rin,
  output logic [7:0]   Rout,
  output logic         Ain,
  output logic         Gin,
  output logic         Gout,
  output logic         DINout,
  output logic [2:0]   AluOp,
  output logic         Done,
  output logic         Busy
`ifdef CTRL_ILLEGAL_EN
  ,
  output logic         Illegal
`endif
);

  typedef enum logic [1:0] {
    T0 = 2'd0,
    T1 = 2'd1,
    T2 = 2'd2,
    T3 = 2'd3
  } step_t;

  typedef struct packed {
    logic [7:0] rin;
    logic [7:0] rout;
    logic       ain;
    logic       gin;
    logic       gout;
    logic       dinout;
    logic [2:0] aluop;
    logic       done;
    logic       busy;
  } ctrl_t;

  // Only the top ten instruction bits carry meaning: opcode, rx, ry.
  step_t      r_step;
  step_t      w_step_nxt;
  logic [9:0] r_ir;
  logic [9:0] w_ir_nxt;
  ctrl_t      r_ctrl;

  function automatic logic is_alu(input logic [3:0] op);
    return op[3] && (op[2:0] <= 3'd5);
  endfunction

  function automatic logic is_undef(input logic [3:0] op);
    return !(op == 4'b0000 || op == 4'b0001 || is_alu(op));
  endfunction

  // Control word for a given step of a given instruction; outputs are a
  // pure function of (step, IR) so no input ever reaches an output.
  function automatic ctrl_t decode(input step_t s, input logic [9:0] f);
    ctrl_t      d;
    logic [3:0] op;
    logic [7:0] rx_oh;
    logic [7:0] ry_oh;
    op    = f[9:6];
    rx_oh = 8'd1 << f[5:3];
    ry_oh = 8'd1 << f[2:0];
    d      = '0;
    d.busy = (s != T0);
    case (s)
      T1: begin
        if (op == 4'b0000) begin
          d.rout = ry_oh;
          d.rin  = rx_oh;
          d.done = 1'b1;
        end else if (op == 4'b0001) begin
          d.dinout = 1'b1;
          d.rin    = rx_oh;
          d.done   = 1'b1;
        end else if (is_alu(op)) begin
          d.rout = rx_oh;
          d.ain  = 1'b1;
        end else begin
          // Undefined opcode: a bare no-op that still signals completion.
          d.done = 1'b1;
        end
      end
      T2: begin
        if (is_alu(op)) begin
          d.rout  = ry_oh;
          d.gin   = 1'b1;
          d.aluop = op[2:0];
        end
      end
      T3: begin
        if (is_alu(op)) begin
          d.gout = 1'b1;
          d.rin  = rx_oh;
          d.done = 1'b1;
        end
      end
      default: d = '0;
    endcase
    return d;
  endfunction

  // Next step / next IR: fetch only in T0, ALU ops take the long path.
  always_comb begin
    w_step_nxt = r_step;
    w_ir_nxt   = r_ir;
    case (r_step)
      T0: begin
        if (Run) begin
          w_ir_nxt   = DIN[W-1:W-10];
          w_step_nxt = T1;
        end
      end
      T1:      w_step_nxt = is_alu(r_ir[9:6]) ? T2 : T0;
      T2:      w_step_nxt = T3;
      T3:      w_step_nxt = T0;
      default: w_step_nxt = T0;
    endcase
  end

  // State, IR and registered control word (decoded from the next state so
  // each output is valid throughout the step it belongs to).
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      r_step <= T0;
      r_ir   <= '0;
      r_ctrl <= '0;
    end else begin
      r_step <= w_step_nxt;
      r_ir   <= w_ir_nxt;
      r_ctrl <= decode(w_step_nxt, w_ir_nxt);
    end
  end

`ifdef CTRL_ILLEGAL_EN
  logic r_illegal;

  // Sticky flag, raised as the undefined instruction enters T1.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      r_illegal <= 1'b0;
    end else if (w_step_nxt == T1 && is_undef(w_ir_nxt[9:6])) begin
      r_illegal <= 1'b1;
    end
  end

  assign Illegal = r_illegal;
`endif

  generate
    if (W > 10) begin : g_unused_din
      logic w_unused_din;
      assign w_unused_din = ^DIN[W-11:0];
    end
  endgenerate

  assign Rin    = r_ctrl.rin;
  assign Rout   = r_ctrl.rout;
  assign Ain    = r_ctrl.ain;
  assign Gin    = r_ctrl.gin;
  assign Gout   = r_ctrl.gout;
  assign DINout = r_ctrl.dinout;
  assign AluOp  = r_ctrl.aluop;
  assign Done   = r_ctrl.done;
  assign Busy   = r_ctrl.busy;

endmodule
`default_nettype wire
